// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;

  // One guard bit above the shifted remainder makes the borrow the sign of the trial result.
  assign w_shift  = {i_rem, i_quo[XLEN-1]};
  assign w_diff   = w_shift - {2'b00, i_divisor};
  assign w_borrow = w_diff[XLEN+1];

  assign o_rem = w_borrow ? w_shift[XLEN:0] : w_diff[XLEN:0];
  assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with register-file write-back outputs.
// Optional macro DIV_EARLY_TERM_EN: skip the iteration loop when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  div_op_t         op,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic [AW-1:0]   rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wen_wb,
  output logic [AW-1:0]   waddr_wb,
  output logic [XLEN-1:0] wdata_wb
);

  div_state_t r_state, w_next;
  logic       w_accept;

  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [5:0]      r_cnt;
  logic            r_sel_rem;
  logic            r_qneg;
  logic            r_rneg;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;

  logic            w_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_div0, w_ovf, w_early, w_special;
  logic            w_qneg, w_rneg;
  logic [XLEN:0]   w_rem_n;
  logic [XLEN-1:0] w_quo_n;
  logic [XLEN-1:0] w_quo_s, w_rem_s, w_result;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & rs1data[XLEN-1];
  assign w_b_neg  = w_signed & rs2data[XLEN-1];
  assign w_a_abs  = w_a_neg ? -rs1data : rs1data;
  assign w_b_abs  = w_b_neg ? -rs2data : rs2data;

  assign w_div0 = (rs2data == '0);
  assign w_ovf  = w_signed && (rs1data == INT_MIN) && (rs2data == ALL_ONES);
`ifdef DIV_EARLY_TERM_EN
  assign w_early = !w_div0 && (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif
  assign w_special = w_div0 | w_ovf | w_early;

  // Divide-by-zero and overflow results are architecturally fixed, so no sign fix-up applies.
  assign w_qneg = (op == DIV) && (w_a_neg ^ w_b_neg) && !w_div0 && !w_ovf;
  assign w_rneg = (op == REM) && w_a_neg && !w_div0 && !w_ovf;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_n),
    .o_quo     (w_quo_n)
  );

  assign w_quo_s  = r_qneg ? -r_quo : r_quo;
  assign w_rem_s  = r_rneg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_result = r_sel_rem ? w_rem_s : w_quo_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start && !flush) begin
          w_accept = 1'b1;
          w_next   = w_special ? FIX : CALC;
        end else if (r_state == DONE) begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (flush)                              w_next = IDLE;
        else if (r_cnt == 6'(DIV_ITER - 1))     w_next = FIX;
      end
      FIX:     w_next = flush ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_rd      <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_sel_rem <= op[1];
      r_rd      <= rd_addr;
      r_div     <= w_b_abs;
      r_cnt     <= '0;
      r_qneg    <= w_qneg;
      r_rneg    <= w_rneg;
      if (w_div0) begin
        r_quo <= ALL_ONES;
        r_rem <= {1'b0, rs1data};
      end else if (w_ovf) begin
        r_quo <= INT_MIN;
        r_rem <= '0;
      end else if (w_early) begin
        r_quo <= '0;
        r_rem <= {1'b0, w_a_abs};
      end else begin
        r_quo <= w_a_abs;
        r_rem <= '0;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt + 6'd1;
    end else if (r_state == FIX && !flush) begin
      r_wdata <= w_result;
      r_waddr <= r_rd;
    end
  end

  assign busy     = (r_state == CALC) || (r_state == FIX);
  assign done     = (r_state == DONE);
  assign wen_wb   = done && (r_waddr != '0);
  assign waddr_wb = r_waddr;
  assign wdata_wb = r_wdata;

endmodule
